// File: rtl/pipeline_dump_sequencer.sv
// Captures a snapshot of the pipeline segment/control registers on request and
// streams it out byte by byte through a one-outstanding-byte UART handshake.
module pipeline_dump_sequencer #(
    parameter int NB_DATA    = 8,
    parameter int NB_ID_EX   = 144,
    parameter int NB_EX_MEM  = 32,
    parameter int NB_MEM_WB  = 48,
    parameter int NB_WB_ID   = 40,
    parameter int NB_CONTROL = 24
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_dump,
    input  logic [NB_ID_EX-1:0]   i_segment_registers_ID_EX,
    input  logic [NB_EX_MEM-1:0]  i_segment_registers_EX_MEM,
    input  logic [NB_MEM_WB-1:0]  i_segment_registers_MEM_WB,
    input  logic [NB_WB_ID-1:0]   i_segment_registers_WB_ID,
    input  logic [NB_CONTROL-1:0] i_control_registers_ID_EX,
    input  logic                  i_txDone,
    output logic                  o_tx_start,
    output logic [NB_DATA-1:0]    o_data,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int NB_SNAP     = NB_ID_EX + NB_EX_MEM + NB_MEM_WB + NB_WB_ID + NB_CONTROL;
    localparam int TOTAL_BYTES = NB_SNAP / NB_DATA;
    localparam int CNT_W       = (TOTAL_BYTES > 1) ? $clog2(TOTAL_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL_BYTES - 1);

    generate
        if ((NB_ID_EX % NB_DATA) != 0 || (NB_EX_MEM % NB_DATA) != 0 ||
            (NB_MEM_WB % NB_DATA) != 0 || (NB_WB_ID % NB_DATA) != 0 ||
            (NB_CONTROL % NB_DATA) != 0) begin : g_bad_width
            $error("pipeline_dump_sequencer: every field width must be a multiple of NB_DATA");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NB_SNAP-1:0]   snap_q, snap_d;
    logic [NB_DATA-1:0]   data_q, data_d;
    logic                 tx_start_q, tx_start_d;

    // Byte 0 is the most significant byte of the concatenated snapshot.
    logic [NB_DATA-1:0] snap_bytes [TOTAL_BYTES];
    generate
        for (genvar gi = 0; gi < TOTAL_BYTES; gi++) begin : g_bytes
            assign snap_bytes[gi] = snap_q[NB_SNAP-1-gi*NB_DATA -: NB_DATA];
        end
    endgenerate

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            snap_q     <= '0;
            data_q     <= '0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            data_q     <= data_d;
            tx_start_q <= tx_start_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        snap_d     = snap_q;
        data_d     = data_q;
        tx_start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_dump) begin
                    snap_d  = {i_segment_registers_ID_EX, i_segment_registers_EX_MEM,
                               i_segment_registers_MEM_WB, i_segment_registers_WB_ID,
                               i_control_registers_ID_EX};
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                data_d  = snap_bytes[cnt_q];
                state_d = START;
            end
            START: begin
                // Registered pulse: visible for the first cycle spent in WAIT.
                tx_start_d = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (i_txDone) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_tx_start = tx_start_q;
    assign o_data     = data_q;
    assign o_busy     = (state_q == LOAD) || (state_q == START) || (state_q == WAIT);
    assign o_done     = (state_q == DONE);

endmodule

// File: tb/tb_pipeline_dump_sequencer.sv
// Directed bench for pipeline_dump_sequencer: streams, frozen snapshot, ignored
// requests, spurious tx-done, asynchronous abort and back-to-back tx-done.
module tb_pipeline_dump_sequencer;

    localparam int NB_DATA    = 8;
    localparam int NB_ID_EX   = 144;
    localparam int NB_EX_MEM  = 32;
    localparam int NB_MEM_WB  = 48;
    localparam int NB_WB_ID   = 40;
    localparam int NB_CONTROL = 24;
    localparam int NBYTES     = 36;

    logic                  clk = 1'b0;
    logic                  i_reset;
    logic                  i_dump;
    logic [NB_ID_EX-1:0]   id_ex;
    logic [NB_EX_MEM-1:0]  ex_mem;
    logic [NB_MEM_WB-1:0]  mem_wb;
    logic [NB_WB_ID-1:0]   wb_id;
    logic [NB_CONTROL-1:0] ctrl;
    logic                  i_txDone;
    logic                  o_tx_start;
    logic [NB_DATA-1:0]    o_data;
    logic                  o_busy;
    logic                  o_done;

    int checks = 0;
    int fails  = 0;
    int starts = 0;
    logic [7:0] exp_bytes [NBYTES];

    always #5 clk = ~clk;

    pipeline_dump_sequencer #(
        .NB_DATA(NB_DATA), .NB_ID_EX(NB_ID_EX), .NB_EX_MEM(NB_EX_MEM),
        .NB_MEM_WB(NB_MEM_WB), .NB_WB_ID(NB_WB_ID), .NB_CONTROL(NB_CONTROL)
    ) dut (
        .clk                        (clk),
        .i_reset                    (i_reset),
        .i_dump                     (i_dump),
        .i_segment_registers_ID_EX  (id_ex),
        .i_segment_registers_EX_MEM (ex_mem),
        .i_segment_registers_MEM_WB (mem_wb),
        .i_segment_registers_WB_ID  (wb_id),
        .i_control_registers_ID_EX  (ctrl),
        .i_txDone                   (i_txDone),
        .o_tx_start                 (o_tx_start),
        .o_data                     (o_data),
        .o_busy                     (o_busy),
        .o_done                     (o_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_golden();
        id_ex  = 144'h0102030405060708090A0B0C0D0E0F101112;
        ex_mem = 32'hA0A1A2A3;
        mem_wb = 48'hB0B1B2B3B4B5;
        wb_id  = 40'hC0C1C2C3C4;
        ctrl   = 24'hD0D1D2;
    endtask

    task automatic set_ff();
        id_ex  = '1;
        ex_mem = '1;
        mem_wb = '1;
        wb_id  = '1;
        ctrl   = '1;
    endtask

    // Pulse i_dump and check the capture-to-start latency.
    task automatic do_dump(input bit corrupt, input bit spurious_load);
        starts   = 0;
        i_dump   = 1'b1;
        tick();
        i_dump   = 1'b0;
        if (corrupt) set_ff();
        if (spurious_load) i_txDone = 1'b1;
        chk("lat_busy_n1", o_busy, 1);
        chk("lat_start_n1", o_tx_start, 0);
        tick();
        i_txDone = 1'b0;
        chk("lat_start_n2", o_tx_start, 0);
        tick();
        chk("lat_start_n3", o_tx_start, 1);
    endtask

    // Acts as the UART transmitter: answers each start with i_txDone after 'delay' cycles.
    task automatic serve(input int delay, input int extra_dump_at, input int abort_at,
                         input bit dump_with_done);
        for (int b = 0; b < NBYTES; b++) begin
            int t = 0;
            while (o_tx_start !== 1'b1 && t < 30) begin
                tick();
                t++;
            end
            chk($sformatf("start_seen_b%0d", b), o_tx_start, 1);
            if (o_tx_start !== 1'b1) return;
            starts++;
            chk($sformatf("data_b%0d", b), o_data, exp_bytes[b]);
            if (b == abort_at) begin
                tick();
                tick();
                #2 i_reset = 1'b1;
                #1;
                chk("abort_tx_start", o_tx_start, 0);
                chk("abort_data", o_data, 0);
                chk("abort_busy", o_busy, 0);
                chk("abort_done", o_done, 0);
                tick();
                i_reset = 1'b0;
                tick();
                chk("abort_idle_busy", o_busy, 0);
                chk("abort_idle_done", o_done, 0);
                return;
            end
            for (int i = 1; i <= delay; i++) begin
                tick();
                i_dump = (b == extra_dump_at && i == 1);
                chk($sformatf("hold_data_b%0d", b), o_data, exp_bytes[b]);
                chk($sformatf("single_start_b%0d", b), o_tx_start, 0);
            end
            i_txDone = 1'b1;
            tick();
            i_txDone = 1'b0;
            i_dump   = 1'b0;
            if (b == NBYTES - 1) begin
                chk("done_rise", o_done, 1);
                chk("busy_fall_with_done", o_busy, 0);
                chk("counter_last", dut.cnt_q, NBYTES - 1);
                if (dump_with_done) i_dump = 1'b1;
                tick();
                i_dump = 1'b0;
                chk("done_one_cycle", o_done, 0);
            end else begin
                chk($sformatf("busy_after_b%0d", b), o_busy, 1);
                chk($sformatf("no_early_done_b%0d", b), o_done, 0);
            end
        end
    endtask

    // Nothing may happen while idle.
    task automatic idle_watch(input string tag, input int n);
        int activity = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (o_busy !== 1'b0 || o_done !== 1'b0 || o_tx_start !== 1'b0) activity++;
        end
        chk(tag, activity, 0);
    endtask

    initial begin
        for (int i = 0; i < 18; i++) exp_bytes[i] = 8'(i + 1);
        for (int i = 0; i < 4; i++)  exp_bytes[18 + i] = 8'hA0 + 8'(i);
        for (int i = 0; i < 6; i++)  exp_bytes[22 + i] = 8'hB0 + 8'(i);
        for (int i = 0; i < 5; i++)  exp_bytes[28 + i] = 8'hC0 + 8'(i);
        for (int i = 0; i < 3; i++)  exp_bytes[33 + i] = 8'hD0 + 8'(i);

        i_dump   = 1'b0;
        i_txDone = 1'b0;
        set_golden();
        i_reset  = 1'b0;
        #1 i_reset = 1'b1;
        #1;
        chk("reset_tx_start", o_tx_start, 0);
        chk("reset_data", o_data, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_done", o_done, 0);
        chk("reset_counter", dut.cnt_q, 0);
        tick();
        tick();
        i_reset = 1'b0;
        tick();

        // Full stream, 10-cycle tx-done, spurious tx-done in IDLE and in LOAD.
        i_txDone = 1'b1;
        tick();
        i_txDone = 1'b0;
        chk("spurious_idle_busy", o_busy, 0);
        chk("spurious_idle_counter", dut.cnt_q, 0);
        do_dump(1'b0, 1'b1);
        serve(10, -1, -1, 1'b0);
        chk("run1_starts", starts, NBYTES);
        idle_watch("run1_idle_quiet", 12);

        // Inputs corrupted after capture, extra dump mid-stream and with o_done.
        do_dump(1'b1, 1'b0);
        serve(10, 5, -1, 1'b1);
        chk("run2_starts", starts, NBYTES);
        idle_watch("run2_no_second_dump", 15);
        set_golden();

        // Asynchronous reset during WAIT of byte 20, then restart from byte 0.
        do_dump(1'b0, 1'b0);
        serve(10, -1, 20, 1'b0);
        chk("run3_starts_before_abort", starts, 21);
        idle_watch("run3_abort_quiet", 10);

        // Tx-done on the cycle right after each start.
        do_dump(1'b0, 1'b0);
        serve(1, -1, -1, 1'b0);
        chk("run4_starts", starts, NBYTES);
        idle_watch("run4_idle_quiet", 8);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipeline_dump_sequencer.md
PIPELINE_DUMP_SEQUENCER -- requirements
Module: pipeline_dump_sequencer

Interface
REQ-001 SHALL have parameters: NB_DATA, 8, UART byte width; NB_ID_EX, 144, ID/EX snapshot width; NB_EX_MEM, 32, EX/MEM width; NB_MEM_WB, 48, MEM/WB width; NB_WB_ID, 40, WB/ID width; NB_CONTROL, 24, control snapshot width.
REQ-002 SHALL have ports:
- clk, in, 1: single clock; all logic on its rising edge.
- i_reset, in, 1: asynchronous, active-high reset.
- i_dump, in, 1: one-cycle request to capture and transmit a pipeline snapshot.
- i_segment_registers_ID_EX, in, NB_ID_EX: live ID/EX contents.
- i_segment_registers_EX_MEM, in, NB_EX_MEM: live EX/MEM contents.
- i_segment_registers_MEM_WB, in, NB_MEM_WB: live MEM/WB contents.
- i_segment_registers_WB_ID, in, NB_WB_ID: live WB/ID contents.
- i_control_registers_ID_EX, in, NB_CONTROL: live ID/EX control bits.
- i_txDone, in, 1: one-cycle pulse from the UART TX when a byte has finished.
- o_tx_start, out, 1: one-cycle pulse to start a UART byte.
- o_data, out, NB_DATA: byte to transmit; held stable from o_tx_start until the matching i_txDone.
- o_busy, out, 1: high from capture until the last i_txDone.
- o_done, out, 1: one-cycle pulse after the last byte completes.

Function
REQ-003 SHALL implement FSM states IDLE, LOAD, START, WAIT, DONE.
REQ-004 IDLE: on i_dump=1, capture all five inputs into one snapshot register (288 bits at defaults), clear the byte counter, go to LOAD.
REQ-005 LOAD: drive o_data with byte[counter], go to START.
REQ-006 START: assert o_tx_start for exactly one cycle, go to WAIT.
REQ-007 WAIT: on i_txDone=1, if counter = TOTAL_BYTES-1 go to DONE; otherwise increment counter and go to LOAD.
REQ-008 DONE: assert o_done for one cycle, return to IDLE.
REQ-009 TOTAL_BYTES SHALL be (NB_ID_EX+NB_EX_MEM+NB_MEM_WB+NB_WB_ID+NB_CONTROL)/NB_DATA, 36 at defaults; the counter SHALL be ceil(log2(TOTAL_BYTES)) bits wide and SHALL never exceed TOTAL_BYTES-1.
REQ-010 Every width parameter SHALL be a multiple of NB_DATA; otherwise elaboration SHALL fail.
REQ-011 Byte order SHALL be ID_EX, EX_MEM, MEM_WB, WB_ID, CONTROL, each field most-significant byte first; byte 0 is ID_EX[143:136].
REQ-012 The snapshot SHALL be frozen from capture until DONE; later changes on the segment inputs SHALL NOT affect bytes being sent.
REQ-013 Latency: i_dump at edge N gives o_busy=1 after edge N and o_tx_start=1 in the cycle after edge N+2.
REQ-014 i_dump while o_busy=1 SHALL be ignored: no recapture, no queueing.
REQ-015 i_txDone outside WAIT SHALL be ignored.
REQ-016 i_dump arriving in the same cycle as o_done SHALL be ignored; a new dump is accepted only in IDLE.
REQ-017 o_tx_start SHALL NOT re-assert before the i_txDone for the previous byte; there is exactly one outstanding byte.
REQ-018 o_busy SHALL be 1 in LOAD, START and WAIT, and 0 in IDLE and DONE.

Reset
REQ-019 i_reset=1 SHALL immediately force state IDLE, counter 0, snapshot 0, o_tx_start=0, o_data=0, o_busy=0, o_done=0, regardless of clock.
REQ-020 Reset mid-transfer SHALL abort without completing the byte or pulsing o_done; the first dump after release SHALL restart at byte 0.

Verification
REQ-021 Inputs ID_EX=0x0102...12 (bytes 1 to 18), EX_MEM=0xA0A1A2A3, MEM_WB=0xB0..B5, WB_ID=0xC0..C4, CONTROL=0xD0D1D2; pulse i_dump; model i_txDone 10 cycles after each start -> 36 starts with bytes 01..12,A0..A3,B0..B5,C0..C4,D0..D2 in order, then one o_done.
REQ-022 Change all segment inputs to 0xFF.. one cycle after i_dump -> transmitted stream is unchanged from the captured values.
REQ-023 Pulse i_dump at byte 5 and again with o_done -> no recapture, total of exactly 36 starts, no second o_done.
REQ-024 Inject a spurious i_txDone in IDLE and in LOAD -> counter does not advance and no byte is skipped.
REQ-025 Assert i_reset during WAIT of byte 20 -> all outputs 0 asynchronously; the next i_dump sends byte 0 first.
REQ-026 i_txDone returned in the cycle after o_tx_start, for all bytes -> 36 bytes, counter stops at 35, o_busy falls on the cycle o_done rises.
